shift_permute_engine: RTL and testbench

- Parametrised byte-lane permutation engine that encodes and decodes data words.
- A key is loaded and reduced to a start offset by summing its bytes modulo the lane count.
- Data words are then permuted with a fixed odd stride, one lane per cycle, through valid/ready handshakes on input and output.
- Sits between the vote-record buffer and the storage/transmit path; the matching decode mode is used on readback.

---
 rtl/shift_permute_engine.sv | 232 +++++++++++++++++++++++
 tb/tb_shift_permute_engine.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_permute_engine.sv
// Byte-lane permutation engine: a key reduced mod NUM_BYTES picks the start lane,
// then lanes are gathered (encode) or scattered (decode) with a fixed odd stride.
// Optional PERM_CHECKSUM_EN adds an XOR-of-lanes csum output and its checker.

module shift_permute_engine #(
   parameter int NUM_BYTES = 8,
   parameter int BYTE_W    = 8,
   parameter int STRIDE    = 7
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        key_load,
   input  logic [NUM_BYTES*BYTE_W-1:0] key,
   output logic                        key_valid,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [NUM_BYTES*BYTE_W-1:0] data_in,
   input  logic                        mode,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [NUM_BYTES*BYTE_W-1:0] data_out,
   output logic                        busy
`ifdef PERM_CHECKSUM_EN
   ,
   output logic [BYTE_W-1:0]           csum
`endif
);

   localparam int IW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam logic [IW-1:0] STRIDE_STEP = IW'(STRIDE % NUM_BYTES);
   localparam logic [IW-1:0] LAST_LANE   = IW'(NUM_BYTES - 1);

   generate
      if ((STRIDE % 2) == 0) begin : g_bad_stride
         $fatal(1, "shift_permute_engine: STRIDE must be odd");
      end
      if ((NUM_BYTES < 2) || (NUM_BYTES > 64) || ((NUM_BYTES & (NUM_BYTES - 1)) != 0)) begin : g_bad_lanes
         $fatal(1, "shift_permute_engine: NUM_BYTES must be a power of 2 in 2..64");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_KEY   = 3'd1,
      S_READY = 3'd2,
      S_PERM  = 3'd3,
      S_OUT   = 3'd4
   } state_t;

   state_t                      r_state;
   state_t                      w_state_next;
   logic [NUM_BYTES*BYTE_W-1:0] r_key;
   logic [NUM_BYTES*BYTE_W-1:0] r_data;
   logic [NUM_BYTES*BYTE_W-1:0] r_data_out;
   logic [IW-1:0]               r_acc;
   logic [IW-1:0]               r_start;
   logic [IW-1:0]               r_cnt;
   logic [IW-1:0]               r_idx;
   logic                        r_mode;
   logic                        r_key_valid;
   logic                        r_in_ready;
   logic                        r_out_valid;
   logic                        r_busy;
   logic                        w_cnt_last;
   logic                        w_out_valid_next;
   logic [IW-1:0]               w_acc_sum;
   int                          w_cnt_lsb;
   int                          w_idx_lsb;

   assign w_cnt_lsb  = int'(r_cnt) * BYTE_W;
   assign w_idx_lsb  = int'(r_idx) * BYTE_W;
   assign w_cnt_last = (r_cnt == LAST_LANE);
   // Only the low IW bits of each key lane matter: the sum is taken mod NUM_BYTES.
   assign w_acc_sum  = r_acc + IW'(r_key[w_cnt_lsb +: BYTE_W]);

   // Next-state logic; key_load wins over in_valid in READY.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (key_load) w_state_next = S_KEY;
            else          w_state_next = S_IDLE;
         end
         S_KEY: begin
            if (w_cnt_last) w_state_next = S_READY;
            else            w_state_next = S_KEY;
         end
         S_READY: begin
            if (key_load)      w_state_next = S_KEY;
            else if (in_valid) w_state_next = S_PERM;
            else               w_state_next = S_READY;
         end
         S_PERM: begin
            if (w_cnt_last) w_state_next = S_OUT;
            else            w_state_next = S_PERM;
         end
         S_OUT: begin
            if (r_out_valid && out_ready) w_state_next = S_READY;
            else                          w_state_next = S_OUT;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // out_valid trails entry into OUT by one cycle and drops with the handshake.
   assign w_out_valid_next = (r_state == S_OUT) && (w_state_next == S_OUT);

   // State register and registered handshake/status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_key_valid <= 1'b0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_key_valid <= (w_state_next == S_READY);
         r_in_ready  <= (w_state_next == S_READY);
         r_out_valid <= w_out_valid_next;
         r_busy      <= (w_state_next == S_KEY) || (w_state_next == S_PERM) ||
                        (w_state_next == S_OUT);
      end
   end

   // Key reduction, word capture and one-lane-per-cycle permutation datapath.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_key      <= '0;
         r_data     <= '0;
         r_data_out <= '0;
         r_acc      <= '0;
         r_start    <= '0;
         r_cnt      <= '0;
         r_idx      <= '0;
         r_mode     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_READY: begin
               if (key_load) begin
                  r_key <= key;
                  r_acc <= '0;
                  r_cnt <= '0;
               end else if ((r_state == S_READY) && in_valid) begin
                  r_data <= data_in;
                  r_mode <= mode;
                  r_cnt  <= '0;
                  r_idx  <= r_start;
               end
            end
            S_KEY: begin
               r_acc <= w_acc_sum;
               r_cnt <= r_cnt + {{(IW-1){1'b0}}, 1'b1};
               if (w_cnt_last) r_start <= w_acc_sum;
            end
            S_PERM: begin
               r_cnt <= r_cnt + {{(IW-1){1'b0}}, 1'b1};
               r_idx <= r_idx + STRIDE_STEP;
               if (r_mode) r_data_out[w_idx_lsb +: BYTE_W] <= r_data[w_cnt_lsb +: BYTE_W];
               else        r_data_out[w_cnt_lsb +: BYTE_W] <= r_data[w_idx_lsb +: BYTE_W];
            end
            default: ;
         endcase
      end
   end

   assign key_valid = r_key_valid;
   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;
   assign data_out  = r_data_out;

`ifdef PERM_CHECKSUM_EN
   logic [BYTE_W-1:0] r_csum;

   // XOR of input lanes, folded in one lane per PERM cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_csum <= '0;
      end else if ((r_state == S_READY) && !key_load && in_valid) begin
         r_csum <= '0;
      end else if (r_state == S_PERM) begin
         r_csum <= r_csum ^ r_data[w_cnt_lsb +: BYTE_W];
      end
   end

   assign csum = r_csum;

   shift_permute_engine_csum_chk #(
      .NUM_BYTES (NUM_BYTES),
      .BYTE_W    (BYTE_W)
   ) u_csum_chk (
      .clk       (clk),
      .rst       (rst),
      .out_valid (r_out_valid),
      .data_out  (r_data_out),
      .csum      (r_csum)
   );
`endif

endmodule

`ifdef PERM_CHECKSUM_EN
// Checker: a permutation preserves the XOR of all lanes.
module shift_permute_engine_csum_chk #(
   parameter int NUM_BYTES = 8,
   parameter int BYTE_W    = 8
) (
   input logic                        clk,
   input logic                        rst,
   input logic                        out_valid,
   input logic [NUM_BYTES*BYTE_W-1:0] data_out,
   input logic [BYTE_W-1:0]           csum
);

   function automatic logic [BYTE_W-1:0] lane_xor(input logic [NUM_BYTES*BYTE_W-1:0] w);
      logic [BYTE_W-1:0] acc;
      acc = '0;
      for (int i = 0; i < NUM_BYTES; i++) acc = acc ^ w[i*BYTE_W +: BYTE_W];
      return acc;
   endfunction

   // Compare the lane XOR of the held output word against csum.
   always_ff @(posedge clk) begin
      if (!rst && out_valid) begin
         assert (lane_xor(data_out) == csum)
            else $error("csum check: data_out lane xor %h vs csum %h", lane_xor(data_out), csum);
      end
   end

endmodule
`endif

// File: tb/tb_shift_permute_engine.sv
// Directed plus randomized bench for shift_permute_engine; instance 0 is the default
// 8-lane/stride-7 build, instance 1 is 16 lanes with stride 5.

module tb_shift_permute_engine;

   logic         clk = 1'b0;
   logic         rst;
   logic         kl   [2];
   logic         iv   [2];
   logic         md   [2];
   logic         ordy [2];
   logic [127:0] kw   [2];
   logic [127:0] din  [2];
   logic         kv   [2];
   logic         ir   [2];
   logic         ov   [2];
   logic         bz   [2];
   logic [63:0]  a_dout;
   logic [127:0] b_dout;
`ifdef PERM_CHECKSUM_EN
   logic [7:0]   a_csum;
   logic [7:0]   b_csum;
`endif

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   shift_permute_engine u_a (
      .clk       (clk),
      .rst       (rst),
      .key_load  (kl[0]),
      .key       (kw[0][63:0]),
      .key_valid (kv[0]),
      .in_valid  (iv[0]),
      .in_ready  (ir[0]),
      .data_in   (din[0][63:0]),
      .mode      (md[0]),
      .out_valid (ov[0]),
      .out_ready (ordy[0]),
      .data_out  (a_dout),
      .busy      (bz[0])
`ifdef PERM_CHECKSUM_EN
      ,
      .csum      (a_csum)
`endif
   );

   shift_permute_engine #(.NUM_BYTES(16), .BYTE_W(8), .STRIDE(5)) u_b (
      .clk       (clk),
      .rst       (rst),
      .key_load  (kl[1]),
      .key       (kw[1]),
      .key_valid (kv[1]),
      .in_valid  (iv[1]),
      .in_ready  (ir[1]),
      .data_in   (din[1]),
      .mode      (md[1]),
      .out_valid (ov[1]),
      .out_ready (ordy[1]),
      .data_out  (b_dout),
      .busy      (bz[1])
`ifdef PERM_CHECKSUM_EN
      ,
      .csum      (b_csum)
`endif
   );

   function automatic logic [127:0] dout(input int s);
      return (s == 0) ? {64'd0, a_dout} : b_dout;
   endfunction

   function automatic int nb_of(input int s);
      return (s == 0) ? 8 : 16;
   endfunction

   function automatic int stride_of(input int s);
      return (s == 0) ? 7 : 5;
   endfunction

   // Reference: start = (sum of key bytes) % nb, lane i pairs with (start + i*stride) % nb.
   function automatic logic [127:0] model(input logic [127:0] k, input logic [127:0] d,
                                          input logic dec, input int nb, input int stride);
      int start;
      int idx;
      logic [127:0] r;
      start = 0;
      r     = '0;
      for (int j = 0; j < nb; j++) start += int'(k[j*8 +: 8]);
      start = start % nb;
      for (int i = 0; i < nb; i++) begin
         idx = (start + i * stride) % nb;
         if (!dec) r[i*8 +: 8]   = d[idx*8 +: 8];
         else      r[idx*8 +: 8] = d[i*8 +: 8];
      end
      return r;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      assert (obs === exp)
         else begin
            n_miss++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
         end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Pulse key_load and measure edges until key_valid (-1 if it never rises).
   task automatic load_key(input int s, input logic [127:0] k, output int lat);
      kw[s] = k;
      kl[s] = 1'b1;
      tick();
      kl[s] = 1'b0;
      lat = -1;
      for (int c = 1; c <= 80; c++) begin
         if (kv[s]) begin
            lat = c - 1;
            break;
         end
         tick();
      end
   endtask

   // Offer one word, optionally pulse key_load pk cycles after acceptance, wait for out_valid.
   task automatic run_word(input int s, input logic [127:0] d, input logic m, input int pk,
                           output logic [127:0] res, output int lat);
      for (int c = 0; c < 80 && !ir[s]; c++) tick();
      din[s] = d;
      md[s]  = m;
      iv[s]  = 1'b1;
      tick();
      iv[s] = 1'b0;
      lat = -1;
      res = '0;
      for (int c = 1; c <= 80; c++) begin
         kl[s] = (c == pk);
         if (c == pk) kw[s] = '0;
         if (ov[s]) begin
            lat = c - 1;
            res = dout(s);
            break;
         end
         tick();
      end
      kl[s] = 1'b0;
`ifdef PERM_CHECKSUM_EN
      begin
         logic [7:0] x;
         x = '0;
         for (int j = 0; j < nb_of(s); j++) x ^= d[j*8 +: 8];
         chk("csum", {120'd0, (s == 0) ? a_csum : b_csum}, {120'd0, x});
      end
`endif
      if (ordy[s]) tick();
   endtask

   initial begin
      logic [127:0] k1;
      logic [127:0] k2;
      logic [127:0] kr;
      logic [127:0] res;
      logic [127:0] enc;
      logic [127:0] x;
      logic [127:0] held;
      logic         any;
      int           lat;
      logic         m;

      k1 = 128'h0102030405060708;
      rst = 1'b1;
      for (int s = 0; s < 2; s++) begin
         kl[s] = 1'b0; iv[s] = 1'b0; md[s] = 1'b0; ordy[s] = 1'b1;
         kw[s] = '0;   din[s] = '0;
      end
      tick();
      tick();
      chk("rst_key_valid", {127'd0, kv[0]}, 128'd0);
      chk("rst_in_ready",  {127'd0, ir[0]}, 128'd0);
      chk("rst_out_valid", {127'd0, ov[0]}, 128'd0);
      chk("rst_busy",      {127'd0, bz[0]}, 128'd0);
      chk("rst_data_out",  dout(0), 128'd0);
      rst = 1'b0;
      tick();
      chk("idle_in_ready", {127'd0, ir[0]}, 128'd0);

      // Worked examples with key 0102..08 (start 4) and all-zero key (start 0).
      load_key(0, k1, lat);
      chk("key_latency", 128'(lat), 128'd8);
      chk("ready_in_ready", {127'd0, ir[0]}, 128'd1);
      run_word(0, 128'h0706050403020100, 1'b0, -1, res, lat);
      chk("enc_k1", res, 128'h0506070001020304);
      chk("out_latency", 128'(lat), 128'd9);
      run_word(0, 128'h0506070001020304, 1'b1, -1, res, lat);
      chk("dec_k1", res, 128'h0706050403020100);
      load_key(0, 128'd0, lat);
      chk("key0_latency", 128'(lat), 128'd8);
      run_word(0, 128'h0706050403020100, 1'b0, -1, res, lat);
      chk("enc_k0", res, 128'h0102030405060700);

      // Backpressure: output held for 5 cycles, released by a one-cycle out_ready pulse.
      load_key(0, k1, lat);
      ordy[0] = 1'b0;
      run_word(0, 128'h0706050403020100, 1'b0, -1, res, lat);
      held = res;
      chk("bp_word", held, 128'h0506070001020304);
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("bp_out_valid", {127'd0, ov[0]}, 128'd1);
         chk("bp_data_stable", dout(0), held);
         chk("bp_in_ready", {127'd0, ir[0]}, 128'd0);
      end
      ordy[0] = 1'b1;
      tick();
      chk("bp_release_ov", {127'd0, ov[0]}, 128'd0);
      chk("bp_release_ir", {127'd0, ir[0]}, 128'd1);
      chk("bp_data_hold", dout(0), held);

      // key_load during PERM is ignored; the following word still uses the old key.
      x = 128'h00000000_00000000_8899aabbccddeeff;
      run_word(0, x, 1'b0, 3, res, lat);
      chk("perm_keyload_ignored", res, model(k1, x, 1'b0, 8, 7));
      chk("perm_keyload_kv", {127'd0, kv[0]}, 128'd1);
      x = {64'd0, rnd128() & 128'hffffffff_ffffffff};
      run_word(0, x, 1'b0, -1, res, lat);
      chk("perm_keyload_next", res, model(k1, x, 1'b0, 8, 7));

      // key_load and in_valid together in READY: reload wins, no word accepted.
      k2 = 128'h00000000_00000000_1122334455667789;
      kw[0] = k2; kl[0] = 1'b1;
      din[0] = 128'h0706050403020100; iv[0] = 1'b1;
      tick();
      kl[0] = 1'b0; iv[0] = 1'b0;
      chk("both_kv_low", {127'd0, kv[0]}, 128'd0);
      chk("both_ir_low", {127'd0, ir[0]}, 128'd0);
      chk("both_busy", {127'd0, bz[0]}, 128'd1);
      any = 1'b0;
      lat = -1;
      for (int c = 1; c <= 80; c++) begin
         any = any | ov[0];
         if (kv[0]) begin
            lat = c - 1;
            break;
         end
         tick();
      end
      chk("both_reload_latency", 128'(lat), 128'd8);
      chk("both_no_word", {127'd0, any}, 128'd0);
      x = 128'h00000000_00000000_f0e1d2c3b4a59687;
      run_word(0, x, 1'b0, -1, res, lat);
      chk("both_new_key", res, model(k2, x, 1'b0, 8, 7));

      // Reset three cycles into PERM discards the word and the key.
      din[0] = 128'h0011223344556677; md[0] = 1'b0; iv[0] = 1'b1;
      tick();
      iv[0] = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_key_valid", {127'd0, kv[0]}, 128'd0);
      chk("midrst_in_ready",  {127'd0, ir[0]}, 128'd0);
      chk("midrst_out_valid", {127'd0, ov[0]}, 128'd0);
      chk("midrst_busy",      {127'd0, bz[0]}, 128'd0);
      chk("midrst_data_out",  dout(0), 128'd0);
      any = 1'b0;
      for (int c = 0; c < 12; c++) begin
         tick();
         any = any | ir[0] | ov[0];
      end
      chk("midrst_stays_idle", {127'd0, any}, 128'd0);
      load_key(0, k2, lat);
      chk("midrst_reload_latency", 128'(lat), 128'd8);
      chk("midrst_ready", {127'd0, ir[0]}, 128'd1);

      // Randomized words on the 8-lane instance against the reference.
      for (int n = 0; n < 60; n++) begin
         if (n % 10 == 0) begin
            kr = rnd128() & 128'hffffffff_ffffffff;
            load_key(0, kr, lat);
            chk("rnd8_key_latency", 128'(lat), 128'd8);
         end
         x = rnd128() & 128'hffffffff_ffffffff;
         m = 1'($urandom_range(0, 1));
         run_word(0, x, m, -1, res, lat);
         chk("rnd8_word", res, model(kr, x, m, 8, 7));
      end

      // 1000 random round trips on the 16-lane stride-5 instance.
      for (int n = 0; n < 1000; n++) begin
         if (n % 100 == 0) begin
            kr = rnd128();
            load_key(1, kr, lat);
            chk("rnd16_key_latency", 128'(lat), 128'd16);
         end
         x = rnd128();
         run_word(1, x, 1'b0, -1, enc, lat);
         if (n == 0) chk("rnd16_out_latency", 128'(lat), 128'd17);
         chk("rnd16_encode", enc, model(kr, x, 1'b0, nb_of(1), stride_of(1)));
         run_word(1, enc, 1'b1, -1, res, lat);
         chk("rnd16_roundtrip", res, x);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
